// File: rtl/dense_acc_bias_sat.sv
// Dense-layer neuron accumulator: seeds with aligned bias, sums N_IN products,
// optional ReLU, then truncates/saturates to OUT_W and holds until taken.
module dense_acc_bias_sat #(
  parameter int N_IN       = 16,
  parameter int PROD_W     = 29,
  parameter int ACC_W      = 36,
  parameter int BIAS_W     = 18,
  parameter int BIAS_SHIFT = 10,
  parameter int OUT_SHIFT  = 10,
  parameter int OUT_W      = 18,
  parameter int RELU       = 0
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic signed [BIAS_W-1:0] bias_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [15:0]              sat_cnt,
  output logic                     busy
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {ACC, FIN, HOLD} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         count;
  logic signed [ACC_W-1:0]  acc;

  logic                     beat, last;
  logic signed [ACC_W-1:0]  prod_x, bias_x, res;
  logic                     sat_hi, sat_lo;
  logic signed [OUT_W-1:0]  clip;

  assign in_ready = (state == ACC);
  assign busy     = (count != '0) || (state != ACC);
  assign beat     = in_valid & in_ready;
  assign last     = (count == CNT_W'(N_IN - 1));
  assign prod_x   = ACC_W'(in_prod);
  assign bias_x   = ACC_W'(bias_in) <<< BIAS_SHIFT;

  // Floor-truncate to output format, then clamp into the OUT_W signed range.
  always_comb begin
    res = acc >>> OUT_SHIFT;
    if (RELU != 0 && res < 0) res = '0;
    sat_hi = (res > OMAX);
    sat_lo = (res < OMIN);
    if (sat_hi)      clip = OMAX[OUT_W-1:0];
    else if (sat_lo) clip = OMIN[OUT_W-1:0];
    else             clip = res[OUT_W-1:0];
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= ACC;
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_cnt   <= '0;
    end else begin
      case (state)
        ACC: if (beat) begin
          // Beat 0 discards whatever acc held and reseeds from the bias.
          acc <= ((count == '0) ? bias_x : acc) + prod_x;
          if (last) begin
            count <= '0;
            state <= FIN;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        FIN: begin
          out_data  <= clip;
          out_valid <= 1'b1;
          if ((sat_hi || sat_lo) && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
          state <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          acc       <= '0;
          state     <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_acc_bias_sat.sv
// Directed + randomized bench for dense_acc_bias_sat: three instances
// (N_IN=4 plain, N_IN=4 ReLU, N_IN=16 plain) checked against an arithmetic model.
module tb_dense_acc_bias_sat;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]         in_valid, out_ready;
  logic [2:0]         in_ready, out_valid, busy;
  logic signed [28:0] in_prod  [3];
  logic signed [17:0] bias_in  [3];
  logic signed [17:0] out_data [3];
  logic [15:0]        sat_cnt  [3];

  int ncmp = 0;
  int nerr = 0;
  int exp_sat [3];

  dense_acc_bias_sat #(.N_IN(4), .RELU(0)) u0 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_prod(in_prod[0]), .bias_in(bias_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .sat_cnt(sat_cnt[0]), .busy(busy[0]));

  dense_acc_bias_sat #(.N_IN(4), .RELU(1)) u1 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_prod(in_prod[1]), .bias_in(bias_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .sat_cnt(sat_cnt[1]), .busy(busy[1]));

  dense_acc_bias_sat #(.N_IN(16), .RELU(0)) u2 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_prod(in_prod[2]), .bias_in(bias_in[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .sat_cnt(sat_cnt[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat, presented so it is taken at the next rising edge.
  task automatic send(input int d, input logic signed [28:0] p, input logic signed [17:0] b);
    in_valid[d] = 1'b1;
    in_prod[d]  = p;
    bias_in[d]  = b;
    tick();
    in_valid[d] = 1'b0;
    in_prod[d]  = 29'($urandom);
    bias_in[d]  = 18'($urandom);
  endtask

  // n identical beats, then the FIN edge; returns with out_valid expected high.
  task automatic neuron(input int d, input int n, input logic signed [17:0] b,
                        input logic signed [28:0] p);
    for (int i = 0; i < n; i++) send(d, p, b);
    tick();
  endtask

  task automatic take(input int d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask

  // Reference: exact sum, floor division by 2^10, optional ReLU, clamp.
  function automatic longint ref_out(input longint sum, input bit relu, output bit sat);
    longint r;
    r   = (sum - (((sum % 1024) + 1024) % 1024)) / 1024;
    sat = 1'b0;
    if (relu && r < 0) r = 0;
    if (r > 131071)       begin r = 131071;  sat = 1'b1; end
    else if (r < -131072) begin r = -131072; sat = 1'b1; end
    return r;
  endfunction

  task automatic rand_neuron(input int d, input bit relu);
    logic signed [17:0] b;
    logic signed [28:0] p;
    longint sum, e;
    bit s;
    int cls;
    b   = 18'($urandom);
    sum = longint'(b) * 1024;
    cls = $urandom_range(0, 3);
    for (int i = 0; i < 4; i++) begin
      case (cls)
        0:       p = 29'($urandom);
        1:       p = 29'(int'($urandom_range(0, 32767)) - 16384);
        default: p = 29'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
      endcase
      sum += longint'(p);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        out_ready[d] = 1'($urandom);
        in_prod[d]   = 29'($urandom);
        tick();
      end
      out_ready[d] = 1'($urandom);
      send(d, p, (i == 0) ? b : 18'($urandom));
    end
    out_ready[d] = 1'b0;
    tick();
    e = ref_out(sum, relu, s);
    if (s && exp_sat[d] != 65535) exp_sat[d]++;
    chk("t6_valid", out_valid[d], 1);
    chk("t6_data", out_data[d], e);
    chk("t6_satcnt", sat_cnt[d], exp_sat[d]);
    for (int k = $urandom_range(0, 3); k > 0; k--) tick();
    chk("t6_hold", out_data[d], e);
    take(d);
    chk("t6_drop", out_valid[d], 0);
  endtask

  initial begin
    logic signed [17:0] held;
    in_valid  = '0;
    out_ready = '0;
    for (int d = 0; d < 3; d++) begin
      in_prod[d] = '0;
      bias_in[d] = '0;
      exp_sat[d] = 0;
    end

    tick(); tick();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", out_valid[d], 0);
      chk("rst_data", out_data[d], 0);
      chk("rst_sat", sat_cnt[d], 0);
      chk("rst_ready", in_ready[d], 1);
      chk("rst_busy", busy[d], 0);
    end

    // T1: 4 x 1024, bias 0 -> 4; check FIN/latency
    for (int i = 0; i < 4; i++) send(0, 29'sd1024, 18'sd0);
    chk("t1_fin_valid", out_valid[0], 0);
    chk("t1_fin_ready", in_ready[0], 0);
    chk("t1_fin_busy", busy[0], 1);
    tick();
    chk("t1_valid", out_valid[0], 1);
    chk("t1_data", out_data[0], 4);
    chk("t1_sat", sat_cnt[0], 0);
    take(0);
    chk("t1_drop", out_valid[0], 0);
    chk("t1_ready", in_ready[0], 1);

    // T2: bias -1, prods -1 -> acc -1028: floor gives -2, ReLU gives 0
    neuron(0, 4, -18'sd1, -29'sd1);
    chk("t2_floor", out_data[0], -2);
    take(0);
    neuron(1, 4, -18'sd1, -29'sd1);
    chk("t2_relu", out_data[1], 0);
    take(1);

    // T3: N_IN=16 saturation both ways
    neuron(2, 16, 18'sd0, 29'sh0FFFFFFF);
    chk("t3_pos", out_data[2], 131071);
    chk("t3_pos_sat", sat_cnt[2], 1);
    take(2);
    neuron(2, 16, 18'sd0, -29'sh0FFFFFFF);
    chk("t3_neg", out_data[2], -131072);
    chk("t3_neg_sat", sat_cnt[2], 2);
    take(2);

    // T4: back-pressure with in_valid held high; no beat until after handshake
    neuron(0, 4, 18'sd3, 29'sd7000);
    held = out_data[0];
    in_valid[0] = 1'b1;
    in_prod[0]  = 29'sd1024;
    bias_in[0]  = 18'sd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stable", out_data[0], held);
      chk("t4_valid", out_valid[0], 1);
      chk("t4_ready", in_ready[0], 0);
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("t4_drop", out_valid[0], 0);
    chk("t4_idle", busy[0], 0);
    tick(); tick(); tick();
    chk("t4_mid", busy[0], 1);
    tick();
    in_valid[0] = 1'b0;
    tick();
    chk("t4_data", out_data[0], 4);
    take(0);

    // T5: reset mid-neuron drops the partial sum
    send(0, 29'sd50000, 18'sd7);
    send(0, 29'sd50000, 18'sd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", busy[0], 0);
    chk("t5_valid", out_valid[0], 0);
    chk("t5_sat2", sat_cnt[2], 0);
    neuron(0, 4, 18'sd0, 29'sd1024);
    chk("t5_data", out_data[0], 4);
    take(0);

    // T6: randomized vs model
    exp_sat[0] = 0;
    exp_sat[1] = 0;
    for (int n = 0; n < 1000; n++) rand_neuron(0, 1'b0);
    for (int n = 0; n < 300; n++) rand_neuron(1, 1'b1);
    chk("t6_final_sat0", sat_cnt[0], exp_sat[0]);
    chk("t6_final_sat1", sat_cnt[1], exp_sat[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
